// File: rtl/tsp_mem_pkg.sv
// Shared types for the vector memory requester: FSM states, vector and latched-instruction types.
package tsp_mem_pkg;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_LEN_W     = 5;
  localparam int DEF_WORD_W    = 16;
  localparam int DEF_ID_W      = 5;
  localparam int DEF_LANES     = 20;
  localparam int DEF_TIMEOUT   = 64;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_WAIT    = 3'd1,
    WR_WAIT    = 3'd2,
    RELEASE    = 3'd3,
    STREAM_OUT = 3'd4
  } mem_req_state_t;

  typedef logic [DEF_WORD_W-1:0] vec_t [DEF_LANES];

  typedef struct packed {
    logic                  is_write;
    logic [DEF_ADDR_W-1:0] address;
    logic [DEF_LEN_W-1:0]  length;
    logic [DEF_ID_W-1:0]   stream_id;
  } mem_instr_t;

  // A vector length is legal when it names at least one and at most all lanes.
  function automatic logic length_ok(input int len, input int max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/mem_req_timeout_counter.sv
// Saturating wait-cycle counter; expired is high during the LIMIT-th counted cycle.
module mem_req_timeout_counter #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_r;

  assign expired = (count_r >= W'(LIMIT - 1));

  // Count cycles spent waiting; hold once expired so the flag stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && !expired) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/vector_mem_requester.sv
// Initiator side of the vector memory port: issues one load/store at a time to the
// memory unit and streams load results out with their stream ID.
module vector_mem_requester
  import tsp_mem_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH      = DEF_ADDR_W,
  parameter int NUM_VECTORS         = DEF_LEN_W,
  parameter int MIN_VEC_LENGTH      = DEF_WORD_W,
  parameter int NUM_STREAM_ID       = DEF_ID_W,
  parameter int NUM_TILES_PER_SLICE = DEF_LANES,
  parameter int TIMEOUT_CYCLES      = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic                      instr_is_write,
  input  logic [MEM_ADDR_WIDTH-1:0] instr_address,
  input  logic [NUM_VECTORS-1:0]    instr_length,
  input  logic [NUM_STREAM_ID-1:0]  instr_stream_id,
  input  logic [MIN_VEC_LENGTH-1:0] instr_write_data [NUM_TILES_PER_SLICE],
  output logic                      mem_read_enable,
  output logic                      mem_write_enable,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [NUM_VECTORS-1:0]    mem_vector_length,
  output logic [MIN_VEC_LENGTH-1:0] mem_write_data [NUM_TILES_PER_SLICE],
  input  logic [MIN_VEC_LENGTH-1:0] mem_read_data [NUM_TILES_PER_SLICE],
  input  logic                      mem_ready,
  output logic                      stream_valid,
  input  logic                      stream_ready,
  output logic [MIN_VEC_LENGTH-1:0] stream_data [NUM_TILES_PER_SLICE],
  output logic [NUM_STREAM_ID-1:0]  stream_id,
  output logic [NUM_VECTORS-1:0]    stream_length,
  output logic                      done_pulse,
  output logic                      err_length,
  output logic                      err_timeout,
  output logic                      busy
);

  mem_req_state_t state_r;
  mem_instr_t     instr_r;
  logic           timed_out_r;
  logic           accept_s;
  logic           len_ok_s;
  logic           in_wait_s;
  logic           expired_s;

  assign accept_s  = (state_r == IDLE) && instr_ready && instr_valid;
  assign len_ok_s  = length_ok(int'(instr_length), NUM_TILES_PER_SLICE);
  assign in_wait_s = (state_r == RD_WAIT) || (state_r == WR_WAIT);

  // Address and length come straight from the latched instruction register.
  assign mem_address       = instr_r.address;
  assign mem_vector_length = instr_r.length;

  mem_req_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept_s),
    .enable  (in_wait_s),
    .expired (expired_s)
  );

  // Request FSM with all interface outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      instr_r          <= '0;
      timed_out_r      <= 1'b0;
      instr_ready      <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      stream_valid     <= 1'b0;
      stream_id        <= '0;
      stream_length    <= '0;
      done_pulse       <= 1'b0;
      err_length       <= 1'b0;
      err_timeout      <= 1'b0;
      busy             <= 1'b0;
      for (int i = 0; i < NUM_TILES_PER_SLICE; i++) begin
        mem_write_data[i] <= '0;
        stream_data[i]    <= '0;
      end
    end else begin
      done_pulse  <= 1'b0;
      err_length  <= 1'b0;
      err_timeout <= 1'b0;
      case (state_r)
        IDLE: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          if (accept_s && len_ok_s) begin
            instr_r <= '{is_write: instr_is_write, address: instr_address,
                         length: instr_length, stream_id: instr_stream_id};
            for (int i = 0; i < NUM_TILES_PER_SLICE; i++) begin
              mem_write_data[i] <= instr_write_data[i];
            end
            timed_out_r      <= 1'b0;
            mem_read_enable  <= !instr_is_write;
            mem_write_enable <= instr_is_write;
            instr_ready      <= 1'b0;
            busy             <= 1'b1;
            state_r          <= instr_is_write ? WR_WAIT : RD_WAIT;
          end else if (accept_s) begin
            err_length <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (mem_ready) begin
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            state_r          <= RELEASE;
            // Lanes beyond the requested length are zeroed rather than passed through.
            if (state_r == RD_WAIT) begin
              for (int i = 0; i < NUM_TILES_PER_SLICE; i++) begin
                stream_data[i] <= (i < int'(instr_r.length)) ? mem_read_data[i] : '0;
              end
            end
          end else if (expired_s) begin
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            timed_out_r      <= 1'b1;
            err_timeout      <= 1'b1;
            state_r          <= RELEASE;
          end else begin
            state_r <= state_r;
          end
        end
        RELEASE: begin
          if (!instr_r.is_write && !timed_out_r) begin
            stream_valid  <= 1'b1;
            stream_id     <= instr_r.stream_id;
            stream_length <= instr_r.length;
            state_r       <= STREAM_OUT;
          end else begin
            done_pulse  <= instr_r.is_write && !timed_out_r;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end
        end
        STREAM_OUT: begin
          if (stream_ready) begin
            stream_valid <= 1'b0;
            done_pulse   <= 1'b1;
            instr_ready  <= 1'b1;
            busy         <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r <= STREAM_OUT;
          end
        end
        default: begin
          mem_read_enable  <= 1'b0;
          mem_write_enable <= 1'b0;
          stream_valid     <= 1'b0;
          instr_ready      <= 1'b0;
          busy             <= 1'b0;
          state_r          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_requester.sv
// Randomized self-checking bench: memory-unit model plus an array-based reference memory.
module tb_vector_mem_requester;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic        instr_is_write;
  logic [9:0]  instr_address;
  logic [4:0]  instr_length;
  logic [4:0]  instr_stream_id;
  logic [15:0] instr_write_data [20];
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [9:0]  mem_address;
  logic [4:0]  mem_vector_length;
  logic [15:0] mem_write_data [20];
  logic [15:0] mem_read_data [20];
  logic        mem_ready;
  logic        stream_valid;
  logic        stream_ready;
  logic [15:0] stream_data [20];
  logic [4:0]  stream_id;
  logic [4:0]  stream_length;
  logic        done_pulse;
  logic        err_length;
  logic        err_timeout;
  logic        busy;

  vector_mem_requester dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_is_write(instr_is_write), .instr_address(instr_address),
    .instr_length(instr_length), .instr_stream_id(instr_stream_id),
    .instr_write_data(instr_write_data), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_vector_length(mem_vector_length), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready), .stream_valid(stream_valid),
    .stream_ready(stream_ready), .stream_data(stream_data), .stream_id(stream_id),
    .stream_length(stream_length), .done_pulse(done_pulse), .err_length(err_length),
    .err_timeout(err_timeout), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int exp_done = 0, exp_errlen = 0, exp_errto = 0;
  int done_seen = 0, errlen_seen = 0, errto_seen = 0;
  int overlap_cnt = 0, unstable_cnt = 0;
  int en_cnt;
  logic mem_stall;
  logic [15:0] env_mem [1024];
  logic [15:0] ref_mem [1024];
  logic        prev_en;
  logic [9:0]  prev_addr;
  logic [4:0]  prev_len;
  logic [15:0] prev_wdata [20];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory unit model: ready after vector_length enabled cycles, cleared when enables drop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      en_cnt    <= 0;
      for (int i = 0; i < 1024; i++) env_mem[i] <= ref_mem[i];
    end else if (mem_read_enable || mem_write_enable) begin
      if (!mem_ready && !mem_stall) begin
        en_cnt <= en_cnt + 1;
        if (en_cnt + 1 >= int'(mem_vector_length)) begin
          mem_ready <= 1'b1;
          for (int i = 0; i < 20; i++) begin
            if (mem_write_enable && i < int'(mem_vector_length))
              env_mem[10'(int'(mem_address) + i)] <= mem_write_data[i];
            if (mem_read_enable)
              mem_read_data[i] <= (i < int'(mem_vector_length)) ?
                                  env_mem[10'(int'(mem_address) + i)] : 16'($urandom);
          end
        end
      end
    end else begin
      mem_ready <= 1'b0;
      en_cnt    <= 0;
    end
  end

  function automatic logic wdata_changed();
    for (int i = 0; i < 20; i++) if (mem_write_data[i] !== prev_wdata[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Protocol monitor: enable exclusivity, request stability, pulse tallies.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read_enable && mem_write_enable) overlap_cnt <= overlap_cnt + 1;
      if (prev_en && (mem_read_enable || mem_write_enable) &&
          (mem_address !== prev_addr || mem_vector_length !== prev_len || wdata_changed()))
        unstable_cnt <= unstable_cnt + 1;
      if (done_pulse)  done_seen   <= done_seen + 1;
      if (err_length)  errlen_seen <= errlen_seen + 1;
      if (err_timeout) errto_seen  <= errto_seen + 1;
      prev_en   <= mem_read_enable || mem_write_enable;
      prev_addr <= mem_address;
      prev_len  <= mem_vector_length;
      for (int i = 0; i < 20; i++) prev_wdata[i] <= mem_write_data[i];
    end else begin
      prev_en <= 1'b0;
    end
  end

  task automatic issue(input logic w, input logic [9:0] addr, input logic [4:0] len,
                       input logic [4:0] id);
    int n = 0;
    while (!instr_ready && n < 300) begin @(negedge clk); n++; end
    check_eq("ready_before_issue", instr_ready, 1'b1);
    instr_valid = 1'b1; instr_is_write = w; instr_address = addr;
    instr_length = len; instr_stream_id = id;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic run_instr(input logic w, input logic [9:0] addr, input logic [4:0] len,
                           input logic [4:0] id, input int bp, input logic to);
    int en_cycles = 0;
    if (bp > 0) stream_ready = 1'b0;
    issue(w, addr, len, id);
    if (len == 5'd0 || len > 5'd20) begin
      exp_errlen++;
      check_eq("err_length", err_length, 1'b1);
      check_eq("rej_ready", instr_ready, 1'b1);
      check_eq("rej_enables", {mem_read_enable, mem_write_enable}, 2'b00);
      @(negedge clk);
      check_eq("rej_enables2", {mem_read_enable, mem_write_enable, busy}, 3'b000);
      check_eq("err_length_once", err_length, 1'b0);
      return;
    end
    check_eq("first_enable", {mem_read_enable, mem_write_enable}, w ? 2'b01 : 2'b10);
    check_eq("mem_address", mem_address, addr);
    check_eq("mem_vlen", mem_vector_length, len);
    check_eq("busy_not_ready", {busy, instr_ready}, 2'b10);
    if (w) for (int i = 0; i < int'(len); i++) check_eq("mem_wdata", mem_write_data[i], instr_write_data[i]);
    while ((mem_read_enable || mem_write_enable) && en_cycles < 300) begin
      en_cycles++; @(negedge clk);
    end
    check_eq("enabled_cycles", en_cycles, to ? 64 : int'(len) + 1);
    check_eq("err_timeout", err_timeout, to);
    check_eq("release_busy", {busy, stream_valid}, 2'b10);
    @(negedge clk);
    if (w || to) begin
      check_eq("done_store", done_pulse, w && !to);
      check_eq("idle_after", {stream_valid, instr_ready, busy}, 3'b010);
      if (to) exp_errto++;
      else begin
        exp_done++;
        for (int i = 0; i < int'(len); i++) ref_mem[10'(int'(addr) + i)] = instr_write_data[i];
      end
      return;
    end
    check_eq("stream_valid", stream_valid, 1'b1);
    check_eq("stream_id", stream_id, id);
    check_eq("stream_length", stream_length, len);
    for (int i = 0; i < 20; i++)
      check_eq("stream_lane", stream_data[i], (i < int'(len)) ? ref_mem[10'(int'(addr) + i)] : 16'h0);
    for (int k = 0; k < bp; k++) begin
      instr_valid = 1'b1;
      @(negedge clk);
      check_eq("bp_hold", {stream_valid, instr_ready, done_pulse}, 3'b100);
      check_eq("bp_id", stream_id, id);
      check_eq("bp_len", stream_length, len);
      check_eq("bp_lane0", stream_data[0], ref_mem[addr]);
    end
    instr_valid = 1'b0;
    stream_ready = 1'b1;
    @(negedge clk);
    exp_done++;
    check_eq("done_load", {done_pulse, stream_valid, instr_ready}, 3'b101);
    @(negedge clk);
    check_eq("no_accept", {busy, mem_read_enable, mem_write_enable, done_pulse}, 4'b0000);
  endtask

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_is_write = 1'b0; instr_address = '0;
    instr_length = '0; instr_stream_id = '0; stream_ready = 1'b1; mem_stall = 1'b0;
    for (int i = 0; i < 20; i++) instr_write_data[i] = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) ref_mem[i] = 16'h0001 + 16'(2 * i);
    repeat (3) @(negedge clk);
    check_eq("reset_ctrl", {instr_ready, busy, mem_read_enable, mem_write_enable, stream_valid,
                            done_pulse, err_length, err_timeout}, 8'h00);
    check_eq("reset_data", {stream_data[0], stream_data[19], mem_address, stream_id}, 52'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_instr(1'b0, 10'd0, 5'd4, 5'd3, 0, 1'b0);
    for (int i = 0; i < 20; i++) instr_write_data[i] = 16'($urandom);
    instr_write_data[0] = 16'hABCD; instr_write_data[1] = 16'h1234;
    run_instr(1'b1, 10'd8, 5'd2, 5'd0, 0, 1'b0);
    run_instr(1'b0, 10'd8, 5'd2, 5'd6, 0, 1'b0);
    run_instr(1'b0, 10'd5, 5'd0, 5'd1, 0, 1'b0);
    run_instr(1'b0, 10'd5, 5'd21, 5'd1, 0, 1'b0);
    mem_stall = 1'b1;
    run_instr(1'b0, 10'd40, 5'd4, 5'd2, 0, 1'b1);
    mem_stall = 1'b0;
    run_instr(1'b0, 10'd1020, 5'd20, 5'd17, 5, 1'b0);

    mem_stall = 1'b1;
    issue(1'b0, 10'd100, 5'd3, 5'd7);
    repeat (3) @(negedge clk);
    check_eq("pre_reset_busy", {busy, mem_read_enable}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check_eq("async_reset", {instr_ready, busy, mem_read_enable, mem_write_enable,
                                stream_valid, done_pulse}, 6'h00);
    @(negedge clk);
    rst_n = 1'b1; mem_stall = 1'b0;
    run_instr(1'b0, 10'd200, 5'd1, 5'd9, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic w;
      w = 1'($urandom);
      for (int i = 0; i < 20; i++) instr_write_data[i] = 16'($urandom);
      run_instr(w, 10'($urandom), 5'($urandom_range(0, 24)), 5'($urandom),
                int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (2) @(negedge clk);
    check_eq("enable_overlap", overlap_cnt, 0);
    check_eq("request_stable", unstable_cnt, 0);
    check_eq("done_count", done_seen, exp_done);
    check_eq("err_length_count", errlen_seen, exp_errlen);
    check_eq("err_timeout_count", errto_seen, exp_errto);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
